// File: rtl/uart_slot_arbiter.sv
// Arbitrates the shared UART between the four j4 thread slots via a lock register,
// buffering TX and RX bytes in small FIFOs that only the lock owner may touch.
module uart_slot_arbiter #(
  parameter int TX_DEPTH     = 8,
  parameter int RX_DEPTH     = 8,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [1:0]  io_slot,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        uart0_wr,
  output logic [7:0]  uart_w,
  input  logic        uart_tx_busy,
  output logic        uart0_rd,
  input  logic        uart0_valid,
  input  logic [7:0]  uart0_data,
  output logic [2:0]  owner,
  output logic [7:0]  drop_cnt
);

  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int TW  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]  TMAX        = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TXA:0]   TX_FULL_CNT = (TXA + 1)'(TX_DEPTH);
  localparam logic [RXA:0]   RX_FULL_CNT = (RXA + 1)'(RX_DEPTH);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t tx_state, tx_state_next;

  logic [7:0]    tx_mem [TX_DEPTH];
  logic [TXA-1:0] tx_wp, tx_rp;
  logic [TXA:0]  tx_cnt;
  logic [7:0]    rx_mem [RX_DEPTH];
  logic [RXA-1:0] rx_wp, rx_rp;
  logic [RXA:0]  rx_cnt;

  logic          lock_held;
  logic [1:0]    lock_slot;
  logic [TW-1:0] idle_cnt;
  logic          rd_last;

  logic sel_data, sel_status, sel_lock;
  logic is_owner, owner_access, lock_wr;
  logic tx_full, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, data_drop;
  logic unused_bits;

  // Exactly one of the three decode bits must be set for an access to count.
  assign sel_data   =  io_addr[12] & ~io_addr[13] & ~io_addr[14];
  assign sel_status = ~io_addr[12] &  io_addr[13] & ~io_addr[14];
  assign sel_lock   = ~io_addr[12] & ~io_addr[13] &  io_addr[14];
  assign unused_bits = ^{io_addr[15], io_addr[11:0], io_dout[15:8]};

  assign owner        = {lock_held, lock_slot};
  assign is_owner     = lock_held && (lock_slot == io_slot);
  assign owner_access = (io_rd || io_wr) && (sel_data || sel_status || sel_lock) && is_owner;
  assign lock_wr      = io_wr && sel_lock;

  assign tx_full  = (tx_cnt == TX_FULL_CNT);
  assign rx_full  = (rx_cnt == RX_FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  assign tx_push   = io_wr && sel_data && is_owner && (!tx_full || tx_pop);
  assign rx_pop    = io_rd && sel_data && is_owner && !rx_empty;
  assign rx_push   = uart0_valid && !rd_last && (!rx_full || rx_pop);
  assign uart0_rd  = rx_push;
  assign data_drop = (io_wr && sel_data && !tx_push) || (io_rd && sel_data && !is_owner);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_pop        = 1'b0;
    uart0_wr      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_cnt != '0 && !uart_tx_busy) begin
          tx_pop        = 1'b1;
          tx_state_next = TX_SEND;
        end
      end
      TX_SEND: begin
        uart0_wr      = 1'b1;
        tx_state_next = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= io_dout[7:0];
    if (rx_push) rx_mem[rx_wp] <= uart0_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp   <= '0;
      tx_rp   <= '0;
      tx_cnt  <= '0;
      uart_w  <= 8'd0;
      rx_wp   <= '0;
      rx_rp   <= '0;
      rx_cnt  <= '0;
      rd_last <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TXA'(1);
      if (tx_pop) begin
        tx_rp  <= tx_rp + TXA'(1);
        uart_w <= tx_mem[tx_rp];
      end
      tx_cnt  <= tx_cnt + (TXA + 1)'(tx_push) - (TXA + 1)'(tx_pop);
      if (rx_push) rx_wp <= rx_wp + RXA'(1);
      if (rx_pop)  rx_rp <= rx_rp + RXA'(1);
      rx_cnt  <= rx_cnt + (RXA + 1)'(rx_push) - (RXA + 1)'(rx_pop);
      rd_last <= rx_push;
    end
  end

  // Reads with an invalid decode leave the previous read data in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_din   <= 16'd0;
      drop_cnt <= 8'd0;
    end else begin
      if (io_rd) begin
        if (sel_data)        io_din <= rx_pop ? {8'd0, rx_mem[rx_rp]} : 16'd0;
        else if (sel_status) io_din <= {12'd0, tx_full, is_owner, !rx_empty, 1'b1};
        else if (sel_lock)   io_din <= {13'd0, owner};
      end
      if (data_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Any lock write in the timeout cycle takes precedence over the auto-release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_held <= 1'b0;
      lock_slot <= 2'd0;
      idle_cnt  <= '0;
    end else if (lock_wr && io_dout[0] && !lock_held) begin
      lock_held <= 1'b1;
      lock_slot <= io_slot;
      idle_cnt  <= '0;
    end else if (lock_wr && !io_dout[0] && is_owner) begin
      lock_held <= 1'b0;
      lock_slot <= 2'd0;
      idle_cnt  <= '0;
    end else if (owner_access) begin
      idle_cnt <= '0;
    end else if (lock_held && !lock_wr && LOCK_TIMEOUT != 0) begin
      if (idle_cnt == TMAX) begin
        lock_held <= 1'b0;
        lock_slot <= 2'd0;
        idle_cnt  <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_slot_arbiter.sv
// Randomized and directed bench for uart_slot_arbiter, checked against a queue-based
// model of the lock, FIFO occupancy, drop counter and read data.
module tb_uart_slot_arbiter;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  localparam int OP_IDLE  = 0;
  localparam int OP_LOCK1 = 1;
  localparam int OP_LOCK0 = 2;
  localparam int OP_DWR   = 3;
  localparam int OP_DRD   = 4;
  localparam int OP_SRD   = 5;
  localparam int OP_LRD   = 6;
  localparam int OP_BAD   = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_rd, io_wr;
  logic [15:0] io_addr;
  logic [1:0]  io_slot;
  logic [15:0] io_dout;
  logic [15:0] io_din;
  logic        uart0_wr;
  logic [7:0]  uart_w;
  logic        uart_tx_busy;
  logic        uart0_rd;
  logic        uart0_valid;
  logic [7:0]  uart0_data;
  logic [2:0]  owner;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  bit           m_held;
  logic [1:0]   m_slot;
  int           m_idle;
  int           m_drops;
  logic [15:0]  m_din;
  bit           m_rd_last;
  byte unsigned m_txq[$];
  byte unsigned m_rxq[$];
  byte unsigned src_q[$];
  byte unsigned emitted[$];
  int           busy_cnt;
  bit           force_busy;
  bit           last_wr;

  always #5 clk = ~clk;

  uart_slot_arbiter #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
    .io_slot(io_slot), .io_dout(io_dout), .io_din(io_din), .uart0_wr(uart0_wr),
    .uart_w(uart_w), .uart_tx_busy(uart_tx_busy), .uart0_rd(uart0_rd),
    .uart0_valid(uart0_valid), .uart0_data(uart0_data), .owner(owner), .drop_cnt(drop_cnt)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelDrop();
    if (m_drops < 255) m_drops++;
  endtask

  // One bus cycle: drive at negedge, predict, cross the posedge, check at next negedge.
  task automatic applyStimulus(input int op, input logic [1:0] slot, input logic [7:0] data);
    logic [2:0] bad;
    bit own, pop, exp_rd, valid, wr_seen, rd_seen;
    io_addr = {4'h0, 12'($urandom)};
    case (op)
      OP_LOCK1, OP_LOCK0, OP_LRD: io_addr[14] = 1'b1;
      OP_DWR, OP_DRD:             io_addr[12] = 1'b1;
      OP_SRD:                     io_addr[13] = 1'b1;
      OP_BAD: begin
        bad = 3'($urandom) | 3'b001;
        if (bad == 3'b001) bad = 3'b011;
        io_addr[14:12] = bad;
      end
      default: ;
    endcase
    io_rd = (op == OP_DRD || op == OP_SRD || op == OP_LRD);
    io_wr = (op == OP_LOCK1 || op == OP_LOCK0 || op == OP_DWR);
    if (op == OP_BAD) begin
      io_wr = 1'($urandom_range(0, 1));
      io_rd = !io_wr;
    end
    io_slot = slot;
    io_dout = {8'($urandom), data};
    if (op == OP_LOCK1) io_dout[0] = 1'b1;
    if (op == OP_LOCK0) io_dout[0] = 1'b0;
    uart0_valid  = (src_q.size() > 0);
    uart0_data   = uart0_valid ? src_q[0] : 8'h00;
    uart_tx_busy = force_busy || (busy_cnt > 0);
    #1;
    own    = m_held && (m_slot == slot);
    valid  = (op != OP_IDLE && op != OP_BAD);
    pop    = (op == OP_DRD) && own && (m_rxq.size() > 0);
    exp_rd = (src_q.size() > 0) && !m_rd_last && ((m_rxq.size() < DEPTH) || pop);
    checkOutput("uart0_rd", uart0_rd, exp_rd);
    rd_seen = uart0_rd;
    wr_seen = uart0_wr;
    if (wr_seen) begin
      checkOutput("wr_while_busy", uart_tx_busy, 1'b0);
      checkOutput("wr_back_to_back", last_wr, 1'b0);
      emitted.push_back(uart_w);
    end
    case (op)
      OP_DRD: begin
        if (own) m_din = pop ? {8'h00, m_rxq[0]} : 16'h0000;
        else begin
          m_din = 16'h0000;
          modelDrop();
        end
      end
      OP_SRD: m_din = {12'h000, m_txq.size() == DEPTH, own, m_rxq.size() != 0, 1'b1};
      OP_LRD: m_din = {13'h0000, m_held, m_slot};
      OP_DWR: begin
        if (own && m_txq.size() < DEPTH) m_txq.push_back(data);
        else modelDrop();
      end
      default: ;
    endcase
    if (op == OP_LOCK1 && !m_held) begin
      m_held = 1; m_slot = slot; m_idle = 0;
    end else if (op == OP_LOCK0 && own) begin
      m_held = 0; m_slot = 2'd0; m_idle = 0;
    end else if (valid && own) begin
      m_idle = 0;
    end else if (m_held && op != OP_LOCK1 && op != OP_LOCK0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_held = 0; m_slot = 2'd0; m_idle = 0;
      end
    end
    if (pop) void'(m_rxq.pop_front());
    if (exp_rd && src_q.size() > 0) m_rxq.push_back(src_q[0]);
    m_rd_last = exp_rd;
    @(posedge clk);
    if (rd_seen && src_q.size() > 0) void'(src_q.pop_front());
    if (busy_cnt > 0) busy_cnt--;
    if (wr_seen) busy_cnt = $urandom_range(1, 3);
    last_wr = wr_seen;
    @(negedge clk);
    checkOutput("owner", owner, {m_held, m_slot});
    checkOutput("drop_cnt", drop_cnt, m_drops[7:0]);
    checkOutput("io_din", io_din, m_din);
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    io_rd = 1'b0;
    io_wr = 1'b0;
    src_q.delete();
    uart0_valid = 1'b0;
    uart0_data = 8'h00;
    force_busy = 1'b1;
    busy_cnt = 0;
    uart_tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput({tag, "_owner"}, owner, 3'b000);
    checkOutput({tag, "_drop"}, drop_cnt, 8'h00);
    checkOutput({tag, "_din"}, io_din, 16'h0000);
    checkOutput({tag, "_wr"}, uart0_wr, 1'b0);
    checkOutput({tag, "_uart_w"}, uart_w, 8'h00);
    checkOutput({tag, "_rd"}, uart0_rd, 1'b0);
    reset = 1'b0;
    m_held = 0; m_slot = 2'd0; m_idle = 0; m_drops = 0; m_din = 16'h0000;
    m_rd_last = 0; last_wr = 0;
    m_txq.delete(); m_rxq.delete(); emitted.delete();
  endtask

  task automatic claimLock(input logic [1:0] slot);
    if (m_held && m_slot != slot) applyStimulus(OP_LOCK0, m_slot, 8'h00);
    applyStimulus(OP_LOCK1, slot, 8'h00);
    checkOutput("claim_owner", owner, {1'b1, slot});
  endtask

  // Lets the UART model consume everything queued, then compares the byte stream.
  task automatic drainTx(input string tag);
    force_busy = 1'b0;
    for (int i = 0; i < 150 && emitted.size() < m_txq.size(); i++)
      applyStimulus(OP_IDLE, 2'd0, 8'h00);
    repeat (6) applyStimulus(OP_IDLE, 2'd0, 8'h00);
    checkOutput({tag, "_count"}, 16'(emitted.size()), 16'(m_txq.size()));
    for (int i = 0; i < m_txq.size() && i < emitted.size(); i++)
      checkOutput({tag, "_byte"}, emitted[i], m_txq[i]);
    emitted.delete();
    m_txq.delete();
  endtask

  initial begin
    io_addr = 16'h0000;
    io_slot = 2'd0;
    io_dout = 16'h0000;
    @(negedge clk);
    doReset("rst0");
    applyStimulus(OP_SRD, 2'd0, 8'h00);
    checkOutput("status_reset", io_din, 16'h0001);

    $display("[TB] scenario: lock and transmit");
    force_busy = 1'b0;
    claimLock(2'd2);
    checkOutput("t1_owner", owner, 3'b110);
    applyStimulus(OP_DWR, 2'd2, 8'h41);
    applyStimulus(OP_DWR, 2'd2, 8'h42);
    drainTx("t1");

    $display("[TB] scenario: non-owner rejection and handover");
    claimLock(2'd2);
    applyStimulus(OP_DWR, 2'd1, 8'h55);
    checkOutput("t2_drop", drop_cnt, 8'd1);
    applyStimulus(OP_LOCK1, 2'd1, 8'h00);
    checkOutput("t2_owner_kept", owner, 3'b110);
    applyStimulus(OP_LOCK0, 2'd2, 8'h00);
    applyStimulus(OP_LOCK1, 2'd1, 8'h00);
    checkOutput("t2_owner_new", owner, 3'b101);

    $display("[TB] scenario: TX overflow");
    claimLock(2'd1);
    force_busy = 1'b1;
    for (int i = 0; i < 9; i++) applyStimulus(OP_DWR, 2'd1, 8'(8'h60 + i));
    applyStimulus(OP_SRD, 2'd1, 8'h00);
    checkOutput("t3_full", io_din[3], 1'b1);
    checkOutput("t3_drop", drop_cnt, 8'd2);
    drainTx("t3");

    $display("[TB] scenario: RX back-pressure");
    claimLock(2'd3);
    for (int i = 0; i < 10; i++) src_q.push_back(8'(8'h30 + i));
    repeat (20) applyStimulus(OP_SRD, 2'd3, 8'h00);
    applyStimulus(OP_DRD, 2'd3, 8'h00);
    checkOutput("t4_first", io_din, 16'h0030);
    repeat (12) applyStimulus(OP_DRD, 2'd3, 8'h00);

    $display("[TB] scenario: lock timeout");
    claimLock(2'd0);
    repeat (TMO - 1) applyStimulus(OP_IDLE, 2'd0, 8'h00);
    applyStimulus(OP_LOCK1, 2'd0, 8'h00);
    checkOutput("t5_refresh", owner, 3'b100);
    repeat (TMO - 1) applyStimulus(OP_IDLE, 2'd0, 8'h00);
    checkOutput("t5_before", owner[2], 1'b1);
    applyStimulus(OP_IDLE, 2'd0, 8'h00);
    checkOutput("t5_expired", owner[2], 1'b0);

    $display("[TB] scenario: random traffic");
    force_busy = 1'b1;
    for (int n = 0; n < 600; n++) begin
      int r;
      int op;
      if ($urandom_range(0, 3) == 0 && src_q.size() < 12) src_q.push_back(8'($urandom));
      r = $urandom_range(0, 15);
      if (r < 2)       op = OP_LOCK1;
      else if (r < 3)  op = OP_LOCK0;
      else if (r < 6)  op = OP_DWR;
      else if (r < 8)  op = OP_DRD;
      else if (r < 9)  op = OP_SRD;
      else if (r < 10) op = OP_LRD;
      else if (r < 11) op = OP_BAD;
      else             op = OP_IDLE;
      applyStimulus(op, 2'($urandom), 8'($urandom));
    end
    drainTx("rand");

    $display("[TB] scenario: reset with queued data");
    claimLock(2'd2);
    force_busy = 1'b1;
    applyStimulus(OP_DWR, 2'd2, 8'hA1);
    applyStimulus(OP_DWR, 2'd2, 8'hA2);
    applyStimulus(OP_DWR, 2'd2, 8'hA3);
    src_q.push_back(8'hB1);
    src_q.push_back(8'hB2);
    repeat (4) applyStimulus(OP_SRD, 2'd2, 8'h00);
    doReset("rst6");
    applyStimulus(OP_SRD, 2'd0, 8'h00);
    checkOutput("t6_status", io_din, 16'h0001);
    drainTx("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
